// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Shared definitions for the UART transmitter and receiver on the same link.
//   tx_state_t     - transmitter frame states
//   calc_bit_clks  - clock cycles per line bit, rounded to the nearest integer
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Rounds CLK_HZ/BPS to the nearest whole cycle; no fractional accumulation is done.
  function automatic int calc_bit_clks(input int clk_hz, input int bps);
    return (clk_hz + bps / 2) / bps;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Module: uart_baud_tick
// Free-running bit-period counter that is held at zero by 'start' and emits a
// one-cycle tick when it reaches 'last', then wraps to zero. The caller chooses
// 'last' per field, so one counter can time single bits or a multi-bit stop field.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   start  in   hold/clear the counter at zero (no tick while asserted)
//   last   in   terminal count (period - 1)
//   tick   out  one-cycle pulse in the final cycle of each period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] last,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  // Count 0..last and wrap, so every period lasts exactly last+1 cycles.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (cnt == last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == last) && !start;

endmodule

// File: rtl/uart_tx.sv
// Module: uart_tx
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity bit,
// STOP_BITS stop bits. Accepts bytes over valid/ready and drives the line from a flop.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high (aborts any frame in flight)
//   tx_data   in   byte to send, sampled on accept (tx_valid & tx_ready)
//   tx_valid  in   producer has tx_data
//   tx_ready  out  can accept a byte (IDLE, or final stop-bit cycle)
//   tx        out  serial line, idle high
//   tx_busy   out  frame in progress
//   tx_done   out  one-cycle pulse in the last cycle of the final stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 66_000_000,
  parameter int BITRATE_BPS = 9_600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_CLKS = calc_bit_clks(CLK_HZ, BITRATE_BPS);
  localparam int CNT_W    = $clog2(STOP_BITS * BIT_CLKS);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [IDX_W-1:0]     bit_idx, idx_next;
  logic                 parity_bit, parity_next;
  logic                 tx_q, tx_next;
  logic                 baud_tick;
  logic                 baud_clear;
  logic [CNT_W-1:0]     baud_last;
  logic                 stop_end;
  logic                 accept;

  // The whole stop field is timed as one long period, so two stop bits cost no
  // extra bit counting and the tick marks the final stop cycle directly.
  assign baud_clear = (state == TX_IDLE);
  assign baud_last  = (state == TX_STOP) ? STOP_LAST : BIT_LAST;

  uart_baud_tick #(
    .CNT_W(CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .start(baud_clear),
    .last (baud_last),
    .tick (baud_tick)
  );

  // Accepting in the final stop cycle lets the next start bit follow with no gap.
  assign stop_end = (state == TX_STOP) && baud_tick;
  assign tx_ready = (state == TX_IDLE) || stop_end;
  assign accept   = tx_valid && tx_ready;
  assign tx_done  = stop_end;
  assign tx_busy  = (state != TX_IDLE);
  assign tx       = tx_q;

  // State register; the line flop is loaded with the level of the state being
  // entered, so tx changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TX_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_idx    <= idx_next;
      parity_bit <= parity_next;
      tx_q       <= tx_next;
    end
  end

  // Next-state and next-line-level logic.
  always_comb begin
    state_next  = state;
    shift_next  = shift;
    idx_next    = bit_idx;
    parity_next = parity_bit;
    tx_next     = 1'b1;

    if (accept) begin
      shift_next  = tx_data;
      parity_next = (^tx_data) ^ ODD_BIT;
      state_next  = TX_START;
    end else begin
      case (state)
        TX_START: begin
          if (baud_tick) begin
            state_next = TX_DATA;
            idx_next   = '0;
          end
        end
        TX_DATA: begin
          if (baud_tick) begin
            shift_next = shift >> 1;
            if (bit_idx == IDX_LAST) begin
              state_next = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            end else begin
              idx_next = bit_idx + 1'b1;
            end
          end
        end
        TX_PARITY: begin
          if (baud_tick) state_next = TX_STOP;
        end
        TX_STOP: begin
          if (baud_tick) state_next = TX_IDLE;
        end
        default: state_next = state;
      endcase
    end

    case (state_next)
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = shift_next[0];
      TX_PARITY: tx_next = parity_next;
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench: tb_uart_tx
// Four uart_tx instances at BIT_CLKS=10: 8N1, 8E1, 8O1 and 8N2. Directed frames are
// compared bit-by-bit against expected line levels built from hand-picked bytes.
module tb_uart_tx;

  localparam int BIT_CLKS = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid [4];
  logic [7:0] tx_data  [4];
  logic       tx_ready [4];
  logic       tx       [4];
  logic       tx_busy  [4];
  logic       tx_done  [4];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8),
            .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8),
            .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_8n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; the instance must be idle so the byte is accepted.
  task automatic applyStimulus(input int d, input logic [7:0] b);
    tx_data[d]  = b;
    tx_valid[d] = 1'b1;
    nextCycle();
    tx_valid[d] = 1'b0;
  endtask

  // Called in the first cycle after accept. Checks every bit for BIT_CLKS cycles,
  // a single tx_done in cycle exp_len, tx_ready only in that cycle, tx_busy throughout.
  task automatic runFrame(input int d, input logic [7:0] b, input int par_en,
                          input logic par_bit, input int stops, input int exp_len,
                          input bit disturb, input bit expect_idle, input string tag);
    logic exp_bits [$];
    int   done_cnt = 0;
    int   done_at = -1;
    int   early_ready = 0;
    int   last_ready = 0;
    int   idle_cycles = 0;
    int   k = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (par_en != 0) exp_bits.push_back(par_bit);
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);

    for (int i = 0; i < exp_bits.size(); i++) begin
      int ok = 0;
      for (int c = 0; c < BIT_CLKS; c++) begin
        k++;
        if (tx[d] == exp_bits[i]) ok++;
        if (tx_done[d]) begin
          done_cnt++;
          done_at = k;
        end
        if (tx_ready[d]) begin
          if (k == exp_len) last_ready = 1;
          else early_ready++;
        end
        if (!tx_busy[d]) idle_cycles++;
        if (disturb) begin
          tx_valid[d] = (k < exp_len) ? k[0] : 1'b0;
          tx_data[d]  = 8'($urandom);
        end
        nextCycle();
      end
      checkOutput($sformatf("%s bit%0d cycles", tag, i), ok, BIT_CLKS);
    end
    checkOutput({tag, " done pulses"}, done_cnt, 1);
    checkOutput({tag, " done cycle"}, done_at, exp_len);
    checkOutput({tag, " early ready"}, early_ready, 0);
    checkOutput({tag, " ready last cycle"}, last_ready, 1);
    checkOutput({tag, " busy low cycles"}, idle_cycles, 0);
    if (expect_idle) begin
      checkOutput({tag, " idle tx"}, int'(tx[d]), 1);
      checkOutput({tag, " idle busy"}, int'(tx_busy[d]), 0);
      checkOutput({tag, " idle ready"}, int'(tx_ready[d]), 1);
    end else begin
      checkOutput({tag, " next start tx"}, int'(tx[d]), 0);
      checkOutput({tag, " next start busy"}, int'(tx_busy[d]), 1);
    end
  endtask

  initial begin
    int low_cnt;
    int done_cnt;
    for (int d = 0; d < 4; d++) begin
      tx_valid[d] = 1'b0;
      tx_data[d]  = 8'h00;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) nextCycle();
    checkOutput("reset tx", int'(tx[0]), 1);
    checkOutput("reset ready", int'(tx_ready[0]), 1);
    checkOutput("reset busy", int'(tx_busy[0]), 0);
    checkOutput("reset done", int'(tx_done[0]), 0);
    rst = 1'b0;
    nextCycle();
    for (int d = 0; d < 4; d++) checkOutput($sformatf("idle tx dut%0d", d), int'(tx[d]), 1);

    // 8N1 frame of 0xA5: line 0,1,0,1,0,0,1,0,1,1
    applyStimulus(0, 8'hA5);
    runFrame(0, 8'hA5, 0, 1'b0, 1, 100, 1'b0, 1'b1, "a5");
    repeat (3) nextCycle();

    // Back-to-back 0x00 then 0xFF with valid held high
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    nextCycle();
    tx_data[0] = 8'hFF;
    runFrame(0, 8'h00, 0, 1'b0, 1, 100, 1'b0, 1'b0, "b2b first");
    tx_valid[0] = 1'b0;
    runFrame(0, 8'hFF, 0, 1'b0, 1, 100, 1'b0, 1'b1, "b2b second");

    // Parity on 0x07 (three ones): even -> 1, odd -> 0
    applyStimulus(1, 8'h07);
    runFrame(1, 8'h07, 1, 1'b1, 1, 110, 1'b0, 1'b1, "even");
    applyStimulus(2, 8'h07);
    runFrame(2, 8'h07, 1, 1'b0, 1, 110, 1'b0, 1'b1, "odd");

    // Two stop bits on 0x55
    applyStimulus(3, 8'h55);
    runFrame(3, 8'h55, 0, 1'b0, 2, 110, 1'b0, 1'b1, "2stop");

    // Reset 35 cycles into a 0xC3 frame (data bit 2 = 0 is on the line)
    applyStimulus(0, 8'hC3);
    repeat (34) nextCycle();
    checkOutput("pre-abort tx", int'(tx[0]), 0);
    checkOutput("pre-abort busy", int'(tx_busy[0]), 1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("abort tx", int'(tx[0]), 1);
    checkOutput("abort ready", int'(tx_ready[0]), 1);
    checkOutput("abort busy", int'(tx_busy[0]), 0);
    low_cnt  = 0;
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (!tx[0]) low_cnt++;
      if (tx_done[0]) done_cnt++;
      nextCycle();
    end
    checkOutput("abort line low cycles", low_cnt, 0);
    checkOutput("abort done pulses", done_cnt, 0);
    applyStimulus(0, 8'h3C);
    runFrame(0, 8'h3C, 0, 1'b0, 1, 100, 1'b0, 1'b1, "after abort");

    // Inputs disturbed while busy: frame must be unchanged, no extra frame
    applyStimulus(0, 8'h96);
    runFrame(0, 8'h96, 0, 1'b0, 1, 100, 1'b1, 1'b1, "disturb");
    low_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (!tx[0] || tx_busy[0]) low_cnt++;
      nextCycle();
    end
    checkOutput("disturb extra frame cycles", low_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
